// File: rtl/stage_mem.sv
// stage_mem: RV32 memory stage between EX and WB with a two-state Wishbone-style data bus master.
// Ports: clk_i, rst_i (sync, active-low); EX side valid_i/flush_i/pc_i/instruction_i/funct3_i/alu_d_i/rs2_d_i/
//   is_load_i/is_store_i/e_*_i with stall_o back to EX; dbus_* data bus; WB side valid_o plus registered fields.
module stage_mem (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] rs2_d_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  output logic        stall_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  output logic        dbus_stb_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic [2:0]  funct3_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic killed;
  logic go, mem_op, width_ok, illegal, mis, issue;
  logic [3:0] sel_d;
  logic [31:0] dat_d, lane, ld_d;
  always_comb begin
    go       = valid_i & !flush_i;
    mem_op   = is_load_i | is_store_i;
    // legal codes: 000 001 010 100 101
    width_ok = (funct3_i[1:0] != 2'b11) & !(funct3_i[2] & funct3_i[1]);
    illegal  = e_illegal_inst_i | (mem_op & !width_ok);
    mis      = width_ok & (funct3_i[1:0] == 2'b01 ? alu_d_i[0] :
                           funct3_i[1:0] == 2'b10 ? |alu_d_i[1:0] : 1'b0);
    issue    = go & mem_op & width_ok & !mis & !e_illegal_inst_i & !e_inst_addr_mis_i;
    // EX holds its inputs while stalled, so completion can capture straight from them
    stall_o  = state == IDLE ? issue : !dbus_ack_i;
    sel_d    = funct3_i[1:0] == 2'b00 ? 4'b0001 << alu_d_i[1:0] :
               funct3_i[1:0] == 2'b01 ? (alu_d_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dat_d    = funct3_i[1:0] == 2'b00 ? {4{rs2_d_i[7:0]}} :
               funct3_i[1:0] == 2'b01 ? {2{rs2_d_i[15:0]}} : rs2_d_i;
    lane     = dbus_dat_i >> {alu_d_i[1:0], 3'b000};
    ld_d     = funct3_i == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
               funct3_i == 3'b100 ? {24'b0, lane[7:0]} :
               funct3_i == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
               funct3_i == 3'b101 ? {16'b0, lane[15:0]} : lane;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state             <= IDLE;
      killed            <= 1'b0;
      dbus_addr_o       <= '0;
      dbus_dat_o        <= '0;
      dbus_sel_o        <= '0;
      dbus_we_o         <= 1'b0;
      dbus_cyc_o        <= 1'b0;
      dbus_stb_o        <= 1'b0;
      valid_o           <= 1'b0;
      pc_o              <= '0;
      instruction_o     <= '0;
      alu_d_o           <= '0;
      mem_d_o           <= '0;
      mem_addr_o        <= '0;
      funct3_o          <= '0;
      e_illegal_inst_o  <= 1'b0;
      e_inst_addr_mis_o <= 1'b0;
      e_ld_addr_mis_o   <= 1'b0;
      e_st_addr_mis_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state == IDLE && issue) begin
        state       <= ACCESS;
        killed      <= 1'b0;
        dbus_cyc_o  <= 1'b1;
        dbus_stb_o  <= 1'b1;
        dbus_we_o   <= is_store_i;
        dbus_addr_o <= {alu_d_i[31:2], 2'b00};
        dbus_sel_o  <= sel_d;
        dbus_dat_o  <= dat_d;
      end
      if (state == ACCESS) begin
        if (flush_i) killed <= 1'b1;
        if (dbus_ack_i) begin
          state      <= IDLE;
          dbus_cyc_o <= 1'b0;
          dbus_stb_o <= 1'b0;
          dbus_we_o  <= 1'b0;
        end
      end
      if (!stall_o) begin
        valid_o           <= state == IDLE ? go : !(killed | flush_i);
        pc_o              <= pc_i;
        instruction_o     <= instruction_i;
        alu_d_o           <= alu_d_i;
        mem_addr_o        <= alu_d_i;
        funct3_o          <= funct3_i;
        mem_d_o           <= (state == ACCESS && is_load_i) ? ld_d : 32'b0;
        e_illegal_inst_o  <= go & illegal;
        e_inst_addr_mis_o <= go & e_inst_addr_mis_i;
        e_ld_addr_mis_o   <= go & is_load_i & mis;
        e_st_addr_mis_o   <= go & is_store_i & mis;
      end
    end
  end
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: scoreboard bench for stage_mem; WB results are queued at issue and matched when valid_o appears.
module tb_stage_mem;
  logic clk = 1'b0, rst_i;
  logic valid_i, flush_i, is_load_i, is_store_i, e_illegal_inst_i, e_inst_addr_mis_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, rs2_d_i, dbus_dat_i;
  logic [2:0] funct3_i;
  logic dbus_ack_i, stall_o, dbus_we_o, dbus_cyc_o, dbus_stb_o, valid_o;
  logic [31:0] dbus_addr_o, dbus_dat_o, pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
  logic [3:0] dbus_sel_o;
  logic [2:0] funct3_o;
  logic e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o;
  typedef struct {
    logic [31:0] pc, ins, alu, md;
    logic [2:0] f3;
    logic [3:0] exc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, stall_cnt = 0;
  stage_mem dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .funct3_i(funct3_i), .alu_d_i(alu_d_i), .rs2_d_i(rs2_d_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .e_illegal_inst_i(e_illegal_inst_i),
    .e_inst_addr_mis_i(e_inst_addr_mis_i), .stall_o(stall_o), .dbus_addr_o(dbus_addr_o),
    .dbus_dat_o(dbus_dat_o), .dbus_sel_o(dbus_sel_o), .dbus_we_o(dbus_we_o),
    .dbus_cyc_o(dbus_cyc_o), .dbus_stb_o(dbus_stb_o), .dbus_dat_i(dbus_dat_i),
    .dbus_ack_i(dbus_ack_i), .valid_o(valid_o), .pc_o(pc_o), .instruction_o(instruction_o),
    .alu_d_o(alu_d_o), .mem_d_o(mem_d_o), .mem_addr_o(mem_addr_o), .funct3_o(funct3_o),
    .e_illegal_inst_o(e_illegal_inst_o), .e_inst_addr_mis_o(e_inst_addr_mis_o),
    .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (stall_o) stall_cnt++;
    if (rst_i && valid_o) begin
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("pc_o", pc_o, e.pc);
        check("instruction_o", instruction_o, e.ins);
        check("alu_d_o", alu_d_o, e.alu);
        check("mem_addr_o", mem_addr_o, e.alu);
        check("mem_d_o", mem_d_o, e.md);
        check("funct3_o", {29'b0, funct3_o}, {29'b0, e.f3});
        check("exc", {28'b0, e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o},
              {28'b0, e.exc});
      end
    end
  end
  task automatic idle_in;
    valid_i = 0; flush_i = 0; is_load_i = 0; is_store_i = 0;
    e_illegal_inst_i = 0; e_inst_addr_mis_i = 0;
  endtask
  task automatic drive(input logic ld, st, input logic [2:0] f3, input logic [31:0] pc, addr, rs2);
    valid_i = 1; is_load_i = ld; is_store_i = st; funct3_i = f3;
    pc_i = pc; instruction_i = pc ^ 32'h5a5a; alu_d_i = addr; rs2_d_i = rs2;
  endtask
  task automatic push(input logic [31:0] pc, addr, md, input logic [2:0] f3, input logic [3:0] exc);
    exp_t n;
    n = '{pc, pc ^ 32'h5a5a, addr, md, f3, exc};
    q.push_back(n);
  endtask
  task automatic run_mem(input string tag, input logic ld, st, input logic [2:0] f3,
                         input logic [31:0] pc, addr, rs2, input int k, input logic [31:0] rdat,
                         input logic [3:0] esel, input logic [31:0] edat, emd);
    drive(ld, st, f3, pc, addr, rs2);
    push(pc, addr, emd, f3, 4'b0);
    stall_cnt = 0;
    #1 check({tag, "_stall"}, stall_o, 1);
    tick;
    check({tag, "_cyc_stb"}, {dbus_cyc_o, dbus_stb_o}, 2'b11);
    check({tag, "_we"}, dbus_we_o, st);
    check({tag, "_addr"}, dbus_addr_o, {addr[31:2], 2'b00});
    check({tag, "_sel"}, dbus_sel_o, esel);
    if (st) check({tag, "_dat"}, dbus_dat_o, edat);
    repeat (k - 1) tick;
    if (k > 1) check({tag, "_hold"}, {dbus_cyc_o, dbus_sel_o, dbus_addr_o[27:0]}, {1'b1, esel, addr[27:2], 2'b00});
    dbus_ack_i = 1; dbus_dat_i = rdat;
    tick;
    dbus_ack_i = 0; dbus_dat_i = 0;
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_cyc_drop"}, dbus_cyc_o, 0);
    check({tag, "_stall_cycles"}, stall_cnt, k);
    idle_in;
    tick;
    check({tag, "_valid_pulse"}, valid_o, 0);
  endtask
  task automatic run_pass(input string tag, input logic ld, st, input logic [2:0] f3,
                          input logic [31:0] pc, addr, input logic ill, iam, input logic [3:0] exc);
    drive(ld, st, f3, pc, addr, 32'h0);
    e_illegal_inst_i = ill; e_inst_addr_mis_i = iam;
    push(pc, addr, 32'h0, f3, exc);
    #1 check({tag, "_stall"}, stall_o, 0);
    tick;
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_no_cyc"}, dbus_cyc_o, 0);
    idle_in;
    tick;
  endtask
  initial begin
    rst_i = 0; idle_in; funct3_i = 0; pc_i = 0; instruction_i = 0; alu_d_i = 0; rs2_d_i = 0;
    dbus_dat_i = 0; dbus_ack_i = 0;
    repeat (3) tick;
    check("rst_valid", valid_o, 0);
    check("rst_cyc", {dbus_cyc_o, dbus_stb_o, dbus_we_o}, 0);
    check("rst_stall", stall_o, 0);
    check("rst_pc", pc_o, 0);
    rst_i = 1;
    tick;
    run_mem("lw",  1, 0, 3'b010, 32'h1000, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_mem("lb",  1, 0, 3'b000, 32'h1004, 32'h103, 32'h0, 1, 32'h80123456, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_mem("lbu", 1, 0, 3'b100, 32'h1008, 32'h103, 32'h0, 1, 32'h80123456, 4'b1000, 32'h0, 32'h00000080);
    run_mem("sh",  0, 1, 3'b001, 32'h100C, 32'h202, 32'h1234ABCD, 2, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    run_mem("lh",  1, 0, 3'b001, 32'h1010, 32'h102, 32'h0, 1, 32'h80017FFF, 4'b1100, 32'h0, 32'hFFFF8001);
    run_mem("lhu", 1, 0, 3'b101, 32'h1014, 32'h100, 32'h0, 2, 32'h80017FFF, 4'b0011, 32'h0, 32'h00007FFF);
    run_mem("sb",  0, 1, 3'b000, 32'h1018, 32'h301, 32'h000000AB, 1, 32'h0, 4'b0010, 32'hABABABAB, 32'h0);
    run_mem("sw",  0, 1, 3'b010, 32'h101C, 32'h400, 32'h11223344, 1, 32'h0, 4'b1111, 32'h11223344, 32'h0);
    run_pass("lw_mis", 1, 0, 3'b010, 32'h2000, 32'h101, 0, 0, 4'b0010);
    run_pass("sh_mis", 0, 1, 3'b001, 32'h2004, 32'h203, 0, 0, 4'b0001);
    run_pass("bad_f3", 1, 0, 3'b011, 32'h2008, 32'h100, 0, 0, 4'b1000);
    run_pass("alu",    0, 0, 3'b000, 32'h200C, 32'h12345678, 0, 0, 4'b0000);
    run_pass("up_ill", 1, 0, 3'b010, 32'h2010, 32'h100, 1, 0, 4'b1000);
    run_pass("up_iam", 1, 0, 3'b010, 32'h2014, 32'h100, 0, 1, 4'b0100);
    drive(1, 0, 3'b010, 32'h3000, 32'h100, 0);
    flush_i = 1;
    #1 check("flush_idle_stall", stall_o, 0);
    tick;
    check("flush_idle_valid", valid_o, 0);
    check("flush_idle_cyc", dbus_cyc_o, 0);
    idle_in;
    dbus_ack_i = 1;
    tick;
    dbus_ack_i = 0;
    check("stray_ack_valid", valid_o, 0);
    check("stray_ack_cyc", dbus_cyc_o, 0);
    drive(1, 0, 3'b010, 32'h3004, 32'h100, 0);
    tick;
    check("flush_acc_cyc", dbus_cyc_o, 1);
    flush_i = 1;
    tick;
    flush_i = 0;
    tick;
    check("flush_acc_still_cyc", dbus_cyc_o, 1);
    dbus_ack_i = 1; dbus_dat_i = 32'h55555555;
    tick;
    dbus_ack_i = 0;
    check("flush_acc_cyc_drop", dbus_cyc_o, 0);
    check("flush_acc_valid", valid_o, 0);
    idle_in;
    tick;
    check("flush_acc_after", valid_o, 0);
    drive(0, 1, 3'b010, 32'h3008, 32'h500, 32'hCAFEF00D);
    tick;
    check("rst_acc_cyc", {dbus_cyc_o, dbus_stb_o, dbus_we_o}, 3'b111);
    rst_i = 0;
    tick;
    check("rst_acc_drop", {dbus_cyc_o, dbus_stb_o, dbus_we_o}, 0);
    check("rst_acc_valid", valid_o, 0);
    rst_i = 1; idle_in;
    tick;
    dbus_ack_i = 1;
    tick;
    dbus_ack_i = 0;
    check("late_ack_valid", valid_o, 0);
    check("late_ack_cyc", dbus_cyc_o, 0);
    tick;
    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have no parameters; all widths are fixed at RV32.
REQ-002 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-low.
REQ-004 valid_i, flush_i  in  1 each  EX slot holds an instruction; kill the in-flight instruction.
REQ-005 pc_i, instruction_i  in  32 each  PC and raw word of the EX instruction.
REQ-006 funct3_i  in  3  load/store width code.
REQ-007 alu_d_i, rs2_d_i  in  32 each  ALU result (effective address for memory ops); store data.
REQ-008 is_load_i, is_store_i  in  1 each  memory op decode from EX, mutually exclusive.
REQ-009 e_illegal_inst_i, e_inst_addr_mis_i  in  1 each  exceptions already raised upstream.
REQ-010 stall_o  out  1  EX SHALL hold all inputs stable while high.
REQ-011 dbus_addr_o, dbus_dat_o  out  32 each  word-aligned address; store data.
REQ-012 dbus_sel_o  out  4  byte-lane enables.
REQ-013 dbus_we_o, dbus_cyc_o, dbus_stb_o  out  1 each  write strobe; cycle; strobe.
REQ-014 dbus_dat_i, dbus_ack_i  in  32, 1  read data; transfer complete.
REQ-015 valid_o  out  1  WB slot holds a valid instruction.
REQ-016 pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o  out  32 each  registered to WB.
REQ-017 funct3_o  out  3  registered funct3.
REQ-018 e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o  out  1 each  exception flags to WB.

Function
REQ-019 FSM states: IDLE, ACCESS; all outputs registered except stall_o.
REQ-020 Width by funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes on a memory op SHALL set e_illegal_inst_o.
REQ-021 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> e_ld_addr_mis_o (load) or e_st_addr_mis_o (store); no bus cycle; 1-cycle latency.
REQ-022 Memory op issued only if valid_i & !flush_i & aligned & no upstream exception; otherwise the instruction passes through in 1 cycle.
REQ-023 IDLE, op issued: stall_o=1 combinationally; next edge -> ACCESS, cyc/stb=1, addr={alu_d_i[31:2],2'b00}, we=is_store_i.
REQ-024 Store lanes: B sel=1<<addr[1:0], dat={4{rs2[7:0]}}; H sel=addr[1]?1100:0011, dat={2{rs2[15:0]}}; W sel=1111, dat=rs2.
REQ-025 Load: sel as for store; cyc/stb/addr/sel/we SHALL remain constant until ack.
REQ-026 ACCESS: stall_o=!dbus_ack_i; on ack, next edge drops cyc/stb, returns to IDLE, loads WB outputs, valid_o=1.
REQ-027 Load data: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; store -> mem_d_o=0.
REQ-028 Memory latency: accept at T, bus from T+1, ack at T+k (k>=1), valid_o at T+k+1; non-memory: valid_o at T+1.
REQ-029 mem_addr_o = full unaligned alu_d_i; all other *_o fields are copies of the inputs captured at acceptance.
REQ-030 flush_i in IDLE: valid_o=0 next cycle, no bus cycle.
REQ-031 flush_i in ACCESS: bus cycle completes normally; result discarded (valid_o=0 after ack).
REQ-032 stall_o high and no completion: WB outputs SHALL hold; valid_o=0 (bubble).
REQ-033 ack outside ACCESS SHALL be ignored.

Reset
REQ-034 rst_i low at an edge: state IDLE; all registered outputs 0; cyc/stb/we drop at that edge even mid-ACCESS.
REQ-035 A late ack after reset SHALL be ignored.

Verification
REQ-036 LW addr 0x100, ack at 3rd bus cycle, dat 0xDEADBEEF -> sel 1111, stall 3 cycles, mem_d_o=0xDEADBEEF, valid_o 1 cycle.
REQ-037 LB addr 0x103, dat 0x80xxxxxx -> sel 1000, mem_d_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x202, rs2=0x1234ABCD -> sel 1100, dat 0xABCDABCD, we=1, mem_d_o=0.
REQ-039 LW addr 0x101 -> no cyc, e_ld_addr_mis_o=1, mem_addr_o=0x101, latency 1.
REQ-040 flush_i during ACCESS, ack 2 cycles later -> bus completes, valid_o stays 0.
REQ-041 rst_i low mid-ACCESS -> cyc/stb 0 next edge, valid_o 0, later ack ignored.
